// File: rtl/mdu_iterative_if.sv
// mdu_iterative_if: issue/result bundle of the RV32M multiply/divide unit.
// master drives the request side, slave is the unit itself.
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            i_start;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1_data;
  logic [XLEN-1:0] i_rs2_data;
  logic [4:0]      i_rd_addr;
  logic            i_flush;
  logic            o_busy;
  logic            o_done;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd_addr;
  logic            o_rd_wren;

  modport master (
    output i_start, i_funct3,
    output i_rs1_data, i_rs2_data,
    output i_rd_addr, i_flush,
    input  o_busy, o_done,
    input  o_result, o_rd_addr,
    input  o_rd_wren
  );

  modport slave (
    input  i_start, i_funct3,
    input  i_rs1_data, i_rs2_data,
    input  i_rd_addr, i_flush,
    output o_busy, o_done,
    output o_result, o_rd_addr,
    output o_rd_wren
  );
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV32M multiply/divide unit.
// Define MDU_FAST_MUL_EN for single-cycle multiplies.
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic            i_clk,
  input logic            i_rst,
  mdu_iterative_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(XLEN-1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic [4:0]        rd;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [2*XLEN-1:0] acc;
  logic              neg;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   result;
  logic [4:0]        rd_out;

  logic [2:0]      f_in;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            sa;
  logic            sb;
  logic            neg_in;
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] cap_a;
  logic [XLEN-1:0] cap_b;
  logic [XLEN-1:0] spec_res;

  assign f_in = bus.i_funct3;
  assign rs1  = bus.i_rs1_data;
  assign rs2  = bus.i_rs2_data;

  // MULH/DIV/REM sign both operands, MULHSU only rs1
  assign sa = rs1[XLEN-1] &
    (f_in == 3'd1 || f_in == 3'd2 ||
     f_in == 3'd4 || f_in == 3'd6);
  assign sb = rs2[XLEN-1] &
    (f_in == 3'd1 || f_in == 3'd4 ||
     f_in == 3'd6);

  assign abs_a = sa ? -rs1 : rs1;
  assign abs_b = sb ? -rs2 : rs2;

  // remainder follows the dividend only
  assign neg_in = (f_in[2] & f_in[1]) ?
    sa : (sa ^ sb);

  assign div0 = f_in[2] & (rs2 == '0);
  assign ovf  = f_in[2] & ~f_in[0] &
    (rs1 == MIN_NEG) & (rs2 == ONES);

  assign spec_res = div0 ?
    (f_in[1] ? rs1 : ONES) :
    (f_in[1] ? '0 : MIN_NEG);

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  // shift-add: multiplier sits in the low half
  assign mul_sum =
    {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, op_a};
  assign mul_next = acc[0] ?
    {mul_sum, acc[XLEN-1:1]} :
    {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};

  // restoring divide: remainder high, quotient low
  assign div_diff =
    acc[2*XLEN-1:XLEN-1] - {1'b0, op_b};
  assign div_next = div_diff[XLEN] ?
    {acc[2*XLEN-2:0], 1'b0} :
    {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign mul_full = neg ? -acc : acc;
  assign quo = neg ?
    -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem = neg ?
    -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  assign fix_res = f3[2] ?
    (f3[1] ? rem : quo) :
    ((f3 == 3'd0) ?
      mul_full[XLEN-1:0] :
      mul_full[2*XLEN-1:XLEN]);

  logic            fast_mul;
  logic [XLEN-1:0] fast_res;

`ifdef MDU_FAST_MUL_EN
  logic                     a_sx;
  logic                     b_sx;
  logic signed [2*XLEN+1:0] prod;

  // multiplies keep raw operands plus a 33rd sign bit
  assign cap_a = f_in[2] ? abs_a : rs1;
  assign cap_b = f_in[2] ? abs_b : rs2;
  assign prod =
    $signed({{(XLEN+1){a_sx}}, a_sx, op_a}) *
    $signed({{(XLEN+1){b_sx}}, b_sx, op_b});
  assign fast_mul = ~f3[2];
  assign fast_res = (f3 == 3'd0) ?
    prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // sign-extension bits for the 33x33 product
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_sx <= 1'b0;
      b_sx <= 1'b0;
    end else if (state == IDLE &&
                 bus.i_start && !bus.i_flush) begin
      a_sx <= sa;
      b_sx <= sb;
    end
  end
`else
  assign cap_a    = abs_a;
  assign cap_b    = abs_b;
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  // control FSM with datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      f3     <= '0;
      rd     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else if (bus.i_flush) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            f3   <= f_in;
            rd   <= bus.i_rd_addr;
            op_a <= cap_a;
            op_b <= cap_b;
            acc  <= f_in[2] ?
              {{XLEN{1'b0}}, abs_a} :
              {{XLEN{1'b0}}, abs_b};
            neg  <= neg_in;
            cnt  <= '0;
            busy <= 1'b1;
            if (div0 || ovf) begin
              result <= spec_res;
              rd_out <= bus.i_rd_addr;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (fast_mul) begin
            result <= fast_res;
            rd_out <= rd;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            acc <= f3[2] ? div_next : mul_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          result <= fix_res;
          rd_out <= rd;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy    = busy;
  assign bus.o_done    = done;
  assign bus.o_result  = result;
  assign bus.o_rd_addr = rd_out;
  assign bus.o_rd_wren = done & (rd_out != 5'd0);

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit.
- Consumes the two source operands read from the register file, computes one M-extension result, and produces a single-cycle write request (data, rd address, write enable) for the register-file write port.
- The control path issues an operation with i_start and stalls on o_busy until o_done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > XLEN.

Ports:
- i_clk  in  1  global clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  issue request; sampled only in IDLE.
- i_funct3  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1_data  in  XLEN  operand A (rs1).
- i_rs2_data  in  XLEN  operand B (rs2).
- i_rd_addr  in  5  destination register.
- i_flush  in  1  synchronous abort of any in-flight operation.
- o_busy  out  1  high from the cycle after acceptance until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_result  out  XLEN  result; held until the next accepted start.
- o_rd_addr  out  5  captured rd; held with o_result.
- o_rd_wren  out  1  equals o_done AND (o_rd_addr != 0).

Behaviour:
- Reset (i_rst high, asynchronous) forces:
  - state IDLE;
  - o_busy, o_done, o_rd_wren = 0;
  - o_result = 0, o_rd_addr = 0;
  - all internal registers = 0.
- Reset mid-operation discards the operation; no o_done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On i_start=1 and i_flush=0, capture funct3, rd, and the operands.
  - Signed ops (MULH, DIV, REM, and rs1 only for MULHSU) store absolute values and record the result sign.
  - Go to CALC with counter=0, or go straight to DONE for a special case.
- CALC:
  - Runs exactly XLEN cycles, one bit per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Goes to FIX when counter reaches XLEN-1.
- FIX:
  - Applies two's-complement negation when required.
  - MUL: low half. MULH/MULHSU/MULHU: high half.
  - Quotient sign = signA XOR signB. Remainder sign = signA.
  - Loads o_result, then goes to DONE.
- DONE:
  - o_done=1 for exactly one cycle, then return to IDLE.
  - A new i_start in the IDLE cycle after DONE is accepted (back-to-back issue).
- Latency, with the i_start cycle as cycle 0:
  - Normal ops: o_done high in cycle XLEN+2 (34).
  - Special cases: o_done high in cycle 1.
- Special cases (no iteration):
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- o_busy is high in CALC, FIX, DONE; low in IDLE.
- i_start while not in IDLE is ignored (no queueing).
- i_flush:
  - In any state, next state is IDLE and o_done is suppressed.
  - o_result and o_rd_addr keep their previous values.
  - If i_flush and i_start are asserted together in IDLE, the flush wins and nothing is accepted.
- rd = 0: the operation executes and o_done pulses, but o_rd_wren stays 0.
- Operand inputs are don't-care after the acceptance cycle.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single combinational 33x33 signed multiplier registered in CALC.
  - CALC lasts one cycle and FIX is skipped for multiplies; o_done is high in cycle 2.
  - Divides are unchanged.
- Undefined: all multiplies are iterative, with latency 34 as above.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), rd=5 -> o_result=0xFFFFFFEB, o_rd_wren=1 and o_rd_addr=5 in cycle 34 (cycle 2 with MDU_FAST_MUL_EN); o_busy high cycles 1-34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -20/6 -> 0xFFFFFFFD; REM -20/6 -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done in cycle 1.
- Start DIVU, then assert i_flush at cycle 10 -> no o_done ever; state IDLE; an i_start in cycle 12 is accepted and completes normally in cycle 46. Repeat with i_rst at cycle 10 -> all outputs 0 immediately.
- rd=0 DIVU 9/3 -> o_done=1 with o_rd_wren=0 and o_result=3; a second i_start at cycle 5 is ignored; back-to-back start at cycle 35 is accepted.
